// File: rtl/returns_scanner.sv
// returns_scanner: a 4-entry queue of item words {U,P,C,M}. Items are loaded
// while idle, then scanned out one per cycle to an external combinational
// checker, whose discount/stolen answers are tallied.
// Optional feature: define RETURNS_SCANNER_ALARM_EN to enable the sticky
// stolen-item alarm; otherwise the alarm port is tied to 0.
//
// Handshake: on each cycle with chk_valid=1 the checker must answer
// combinationally on chk_discount/chk_stolen. The scanner samples those answers
// and pops the presented item on the same rising edge. There is no
// back-pressure: items are presented back-to-back.
module returns_scanner (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] item_in,
  input  logic       load,
  input  logic       start,
  output logic [2:0] chk_upc,
  output logic       chk_mark,
  output logic       chk_valid,
  input  logic       chk_discount,
  input  logic       chk_stolen,
  output logic       full,
  output logic       empty,
  output logic       busy,
  output logic       done,
  output logic [2:0] disc_count,
  output logic [2:0] stolen_count,
  output logic       alarm,
  output logic [1:0] dbg_state
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [3:0] r_mem [0:3];
  logic [1:0] r_rd_ptr;
  logic [1:0] r_wr_ptr;
  logic [2:0] r_count;
  logic [1:0] r_state;
  logic [2:0] r_disc;
  logic [2:0] r_stol;

  logic [1:0] w_state_eff;
  logic       w_start_acc;
  logic       w_load_acc;
  logic       w_pop;
  logic [3:0] w_head;

  // DONE behaves as IDLE in any cycle with load or start, so the request is
  // handled in that same cycle.
  always_comb begin
    w_state_eff = r_state;
    if (r_state == DONE && (load || start)) w_state_eff = IDLE;
  end

  assign w_start_acc = (w_state_eff == IDLE) && start;
  assign w_load_acc  = (w_state_eff == IDLE) && load && !start && !full;
  assign w_pop       = (r_state == SCAN);
  assign w_head      = r_mem[r_rd_ptr];

  assign full         = (r_count == 3'd4);
  assign empty        = (r_count == 3'd0);
  assign busy         = (r_state == SCAN);
  assign done         = (r_state == DONE);
  assign chk_valid    = (r_state == SCAN);
  assign chk_upc      = chk_valid ? w_head[3:1] : 3'd0;
  assign chk_mark     = chk_valid ? w_head[0] : 1'b0;
  assign disc_count   = r_disc;
  assign stolen_count = r_stol;
  assign dbg_state    = r_state;

  // Queue storage: write the accepted item at the tail.
  always_ff @(posedge clk) begin
    if (w_load_acc) r_mem[r_wr_ptr] <= item_in;
  end

  // Queue pointers and occupancy; push and pop never coincide.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_ptr <= 2'd0;
      r_wr_ptr <= 2'd0;
      r_count  <= 3'd0;
    end else if (w_load_acc) begin
      r_wr_ptr <= r_wr_ptr + 2'd1;
      r_count  <= r_count + 3'd1;
    end else if (w_pop) begin
      r_rd_ptr <= r_rd_ptr + 2'd1;
      r_count  <= r_count - 3'd1;
    end
  end

  // Control FSM: IDLE -> SCAN (or DONE when empty) -> DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      case (w_state_eff)
        IDLE:    r_state <= start ? ((r_count != 3'd0) ? SCAN : DONE) : IDLE;
        SCAN:    r_state <= (r_count == 3'd1) ? DONE : SCAN;
        DONE:    r_state <= DONE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Tallies: cleared by an accepted start, accumulated on every scan edge.
  // At most four items per scan, so three bits never wrap.
  always_ff @(posedge clk) begin
    if (reset || w_start_acc) begin
      r_disc <= 3'd0;
      r_stol <= 3'd0;
    end else if (w_pop) begin
      r_disc <= r_disc + {2'd0, chk_discount};
      r_stol <= r_stol + {2'd0, chk_stolen};
    end
  end

`ifdef RETURNS_SCANNER_ALARM_EN
  logic r_alarm;
  // Sticky alarm: set by any stolen item seen during a scan.
  always_ff @(posedge clk) begin
    if (reset || w_start_acc) r_alarm <= 1'b0;
    else if (w_pop && chk_stolen) r_alarm <= 1'b1;
  end
  assign alarm = r_alarm;
`else
  assign alarm = 1'b0;
`endif

endmodule

// File: tb/tb_returns_scanner.sv
// Bench for returns_scanner: directed scenarios plus random traffic, checked
// every cycle against a queue-based reference model.
module tb_returns_scanner;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] item_in = 4'd0;
  logic       load = 1'b0;
  logic       start = 1'b0;
  logic [2:0] chk_upc;
  logic       chk_mark, chk_valid, chk_discount, chk_stolen;
  logic       full, empty, busy, done, alarm;
  logic [2:0] disc_count, stolen_count;
  logic [1:0] dbg_state;

`ifdef RETURNS_SCANNER_ALARM_EN
  localparam bit ALARM_ON = 1'b1;
`else
  localparam bit ALARM_ON = 1'b0;
`endif

  returns_scanner dut (
    .clk(clk), .reset(reset), .item_in(item_in), .load(load), .start(start),
    .chk_upc(chk_upc), .chk_mark(chk_mark), .chk_valid(chk_valid),
    .chk_discount(chk_discount), .chk_stolen(chk_stolen),
    .full(full), .empty(empty), .busy(busy), .done(done),
    .disc_count(disc_count), .stolen_count(stolen_count),
    .alarm(alarm), .dbg_state(dbg_state)
  );

  // Clock/reset block
  always #5 clk = ~clk;

  // Checker: discount when P or C is set; stolen when only U is set.
  function automatic logic f_disc(input logic [3:0] it);
    return it[2] | it[1];
  endfunction
  function automatic logic f_stol(input logic [3:0] it);
    return it[3] & ~it[2] & ~it[1] & ~it[0];
  endfunction
  assign chk_discount = chk_valid & f_disc({chk_upc, chk_mark});
  assign chk_stolen   = chk_valid & f_stol({chk_upc, chk_mark});

  // Reference model
  localparam int M_IDLE = 0, M_SCAN = 1, M_DONE = 2;
  logic [3:0] exp_q[$];
  int         m_st = M_IDLE;
  int         m_disc = 0, m_stol = 0;
  bit         m_alarm = 1'b0;
  bit         m_live = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  always @(posedge clk) begin
    logic [3:0] it;
    if (reset) begin
      exp_q.delete();
      m_st = M_IDLE; m_disc = 0; m_stol = 0; m_alarm = 1'b0; m_live = 1'b1;
    end else if (m_live) begin
      if (m_st == M_DONE && (load || start)) m_st = M_IDLE;
      if (m_st == M_IDLE) begin
        if (start) begin
          m_disc = 0; m_stol = 0; m_alarm = 1'b0;
          m_st = (exp_q.size() > 0) ? M_SCAN : M_DONE;
        end else if (load && exp_q.size() < 4) begin
          exp_q.push_back(item_in);
        end
      end else if (m_st == M_SCAN) begin
        it = exp_q.pop_front();
        m_disc += int'(f_disc(it));
        m_stol += int'(f_stol(it));
        if (f_stol(it) && ALARM_ON) m_alarm = 1'b1;
        if (exp_q.size() == 0) m_st = M_DONE;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Scoreboard compare: every cycle on the falling edge.
  always @(negedge clk) begin
    int e_valid, e_upc, e_mark;
    if (m_live) begin
      vectors++;
      e_valid = (m_st == M_SCAN) ? 1 : 0;
      e_upc   = e_valid ? int'(exp_q[0][3:1]) : 0;
      e_mark  = e_valid ? int'(exp_q[0][0]) : 0;
      chk("chk_valid", int'(chk_valid), e_valid);
      chk("chk_upc", int'(chk_upc), e_upc);
      chk("chk_mark", int'(chk_mark), e_mark);
      chk("empty", int'(empty), (exp_q.size() == 0) ? 1 : 0);
      chk("full", int'(full), (exp_q.size() == 4) ? 1 : 0);
      chk("busy", int'(busy), e_valid);
      chk("done", int'(done), (m_st == M_DONE) ? 1 : 0);
      chk("disc_count", int'(disc_count), m_disc);
      chk("stolen_count", int'(stolen_count), m_stol);
      chk("alarm", int'(alarm), int'(m_alarm));
    end
  end

  // Driver: inputs change 2 time units after the rising edge.
  task automatic tick(input logic r, input logic l, input logic s,
                      input logic [3:0] it);
    @(posedge clk);
    #2;
    reset = r; load = l; start = s; item_in = it;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 4'd0);
  endtask

  task automatic load_item(input logic [3:0] it);
    tick(1'b0, 1'b1, 1'b0, it);
    tick(1'b0, 1'b0, 1'b0, 4'd0);
  endtask

  task automatic do_reset();
    tick(1'b1, 1'b0, 1'b0, 4'd0);
    tick(1'b0, 1'b0, 1'b0, 4'd0);
  endtask

  int valid_cycles;

  initial begin
    // Reset state
    tick(1'b1, 1'b0, 1'b0, 4'd0);
    tick(1'b0, 1'b0, 1'b0, 4'd0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_valid", int'(chk_valid), 0);

    // Two items, one discounted and one stolen
    load_item(4'b1000);
    load_item(4'b1010);
    tick(1'b0, 1'b0, 1'b1, 4'd0);
    valid_cycles = 0;
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 1'b0, 1'b0, 4'd0);
      if (chk_valid) valid_cycles++;
    end
    chk("s1_valid_cycles", valid_cycles, 2);
    chk("s1_done", int'(done), 1);
    chk("s1_disc", int'(disc_count), 1);
    chk("s1_stol", int'(stolen_count), 1);
    chk("s1_alarm", int'(alarm), int'(ALARM_ON));

    // Five loads into a 4-deep queue
    for (int i = 0; i < 5; i++) load_item(4'b0100);
    chk("s2_full", int'(full), 1);
    tick(1'b0, 1'b0, 1'b1, 4'd0);
    valid_cycles = 0;
    for (int i = 0; i < 7; i++) begin
      tick(1'b0, 1'b0, 1'b0, 4'd0);
      if (chk_valid) valid_cycles++;
    end
    chk("s2_valid_cycles", valid_cycles, 4);
    chk("s2_disc", int'(disc_count), 4);
    chk("s2_stol", int'(stolen_count), 0);
    chk("s2_alarm", int'(alarm), 0);

    // Start on an empty queue
    do_reset();
    tick(1'b0, 1'b0, 1'b1, 4'd0);
    tick(1'b0, 1'b0, 1'b0, 4'd0);
    chk("s3_done", int'(done), 1);
    chk("s3_valid", int'(chk_valid), 0);
    chk("s3_disc", int'(disc_count), 0);

    // Reset during the first scan cycle
    load_item(4'b1001);
    load_item(4'b1000);
    tick(1'b0, 1'b0, 1'b1, 4'd0);
    tick(1'b1, 1'b0, 1'b0, 4'd0);
    tick(1'b0, 1'b0, 1'b0, 4'd0);
    chk("s4_empty", int'(empty), 1);
    chk("s4_valid", int'(chk_valid), 0);
    chk("s4_stol", int'(stolen_count), 0);
    chk("s4_state_idle", int'(done) + int'(busy), 0);

    // Start and load in the same idle cycle
    load_item(4'b0010);
    tick(1'b0, 1'b1, 1'b1, 4'b1111);
    idle(3);
    chk("s5_done", int'(done), 1);
    chk("s5_empty", int'(empty), 1);
    chk("s5_disc", int'(disc_count), 1);

    // Load while in DONE
    tick(1'b0, 1'b1, 1'b0, 4'b1100);
    tick(1'b0, 1'b0, 1'b0, 4'd0);
    chk("s6_done", int'(done), 0);
    chk("s6_empty", int'(empty), 0);
    chk("s6_disc_kept", int'(disc_count), 1);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      tick(($urandom_range(0, 59) == 0),
           ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 7) == 0),
           4'($urandom_range(0, 15)));
    end
    idle(8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/returns_scanner.md
RETURNS_SCANNER -- requirements
Module: returns_scanner

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all logic on rising edge.
REQ-002 SHALL have ports: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have ports: item_in  in  4  item word {U,P,C,M}, U=bit3, M=bit0.
REQ-004 SHALL have ports: load  in  1  one-cycle pulse, enqueue item_in.
REQ-005 SHALL have ports: start  in  1  one-cycle pulse, begin scan of queue.
REQ-006 SHALL have ports: chk_upc  out  3  {U,P,C} presented to the checker.
REQ-007 SHALL have ports: chk_mark  out  1  M presented to the checker.
REQ-008 SHALL have ports: chk_valid  out  1  chk_upc and chk_mark valid this cycle.
REQ-009 SHALL have ports: chk_discount  in  1  checker discount result, combinational from chk_* signals.
REQ-010 SHALL have ports: chk_stolen  in  1  checker stolen result, combinational from chk_* signals.
REQ-011 SHALL have ports: full, empty, busy, done  out  1 each  queue and FSM status.
REQ-012 SHALL have ports: disc_count, stolen_count  out  3 each  tallies for the last scan.
REQ-013 SHALL have ports: alarm  out  1  stolen-item alarm (see Configuration).

Function
REQ-014 SHALL hold a 4-entry FIFO of item words; full = 4 entries, empty = 0 entries.
REQ-015 SHALL use FSM states IDLE, SCAN and DONE.
REQ-016 SHALL, in IDLE with load=1 and not full, write item_in at the tail; empty deasserts the next cycle.
REQ-017 SHALL ignore load when the FIFO is full, or when the FSM is in SCAN.
REQ-018 SHALL, in IDLE with start=1, clear disc_count and stolen_count and move to SCAN if the FIFO is non-empty, else to DONE.
REQ-019 SHALL, when start and load are asserted together in IDLE, honour start and ignore load.
REQ-020 SHALL, in SCAN, drive chk_upc and chk_mark from the FIFO head with chk_valid=1 every cycle, one item per cycle, back-to-back.
REQ-021 SHALL sample chk_discount and chk_stolen on each SCAN edge and add each to its tally; it SHALL also pop the head on that edge.
REQ-022 SHALL move from SCAN to DONE on the edge that pops the last entry; scan of N items takes exactly N cycles.
REQ-023 SHALL drive chk_upc=0, chk_mark=0 and chk_valid=0 whenever the FSM is outside SCAN.
REQ-024 SHALL assert busy only in SCAN, and assert done only in DONE.
REQ-025 SHALL hold DONE and the tallies until load or start is asserted; the FSM then returns to IDLE and the load or start is processed in that same cycle per REQ-016/018/019.
REQ-026 SHALL size the tallies so they saturate naturally at a maximum of 4 (3 bits); no wrap occurs.
REQ-027 SHALL ignore start while in SCAN.

Reset
REQ-028 SHALL, when reset=1 at a clock edge, flush the FIFO pointers and enter IDLE, including mid-SCAN.
REQ-029 SHALL drive these values after reset: empty=1, full=0, busy=0, done=0, chk_valid=0, chk_upc=0, chk_mark=0, disc_count=0, stolen_count=0, alarm=0.

Configuration
REQ-030 SHALL, with RETURNS_SCANNER_ALARM_EN defined, set alarm to 1 on any SCAN edge with chk_stolen=1; alarm then holds until reset or an accepted start.
REQ-031 SHALL, without RETURNS_SCANNER_ALARM_EN, keep the alarm port present and tie it to 0.

Verification
REQ-032 SHALL cover this scenario: reset, then load 4'b1000 and 4'b1010, then start -> chk_valid high 2 cycles, then done=1, disc_count=1, stolen_count=1, alarm=1 (macro on) or 0 (macro off).
REQ-033 SHALL cover this scenario: load 5 items 4'b0100 -> full=1 after the 4th load, 5th ignored; start -> 4 SCAN cycles, disc_count=4, stolen_count=0.
REQ-034 SHALL cover this scenario: start with an empty FIFO -> next cycle done=1, chk_valid never high, both tallies 0.
REQ-035 SHALL cover this scenario: load 4'b1001 and 4'b1000, start, then reset asserted in the 1st SCAN cycle -> next cycle IDLE, empty=1, tallies 0, chk_valid=0.
REQ-036 SHALL cover this scenario: start and load pulsed in the same IDLE cycle with 1 item queued -> 1-item scan, new item not enqueued, empty=1 at done.
REQ-037 SHALL cover this scenario: in DONE, pulse load 4'b1100 -> done=0, FIFO holds 1 entry, tallies retained until the next start.
